shift_ctl: RTL

Front-end controller that shares the single multi-cycle 32-bit left shifter between two requesters (decode port 0 and port 1).
- Arbitrates between the ports, then issues one start pulse.
- Implements SRL/SRA on the left-only shifter by pre/post bit-reversal and inversion.
- Waits for the shifter's one-cycle ready pulse, then holds the result in a response register until the consumer takes it.

---
 rtl/shift_ctl_pkg.sv | 23 ++
 rtl/shift_ctl_xform.sv | 32 +++
 rtl/shifter32.sv | 36 +++
 rtl/shift_ctl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/shift_ctl_pkg.sv
// rtl/shift_ctl_pkg.sv - shared constants and helpers for the shift controller
// Purpose : direction codes, one-hot FSM state codes and a 32-bit bit reversal.
// Ports   : none (package).
package shift_ctl_pkg;

    localparam logic [1:0] DIR_SLL = 2'b00;
    localparam logic [1:0] DIR_SRL = 2'b01;
    localparam logic [1:0] DIR_SRA = 2'b11;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_START = 4'b0010;
    localparam logic [3:0] ST_BUSY  = 4'b0100;
    localparam logic [3:0] ST_RESP  = 4'b1000;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_ctl_xform.sv
// rtl/shift_ctl_xform.sv - pre/post operand transform around a left-only shifter
// Purpose : maps SRL/SRA onto a left shift by bit reversal (and sign inversion
//           for SRA) before the shifter, and undoes it after.
// Ports   : operand_i - value to transform
//           dir_i     - shift direction code (2'b10 behaves as SLL)
//           sign_i    - sign of the original operand (used by SRA only)
//           post_i    - 0 = pre-shift transform, 1 = post-shift transform
//           result_o  - transformed value
module shift_ctl_xform
    import shift_ctl_pkg::*;
(
    input  logic [31:0] operand_i,
    input  logic [1:0]  dir_i,
    input  logic        sign_i,
    input  logic        post_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = operand_i;
        case (dir_i)
            DIR_SRL: result_o = bitrev(operand_i);
            // SRA: inverting a negative value turns sign fill into zero fill,
            // so a logical right shift of the inverted value is correct once
            // the inversion is undone on the way out.
            DIR_SRA: result_o = post_i ? (bitrev(operand_i) ^ {32{sign_i}})
                                       : bitrev(operand_i ^ {32{sign_i}});
            default: result_o = operand_i;
        endcase
    end

endmodule

// File: rtl/shifter32.sv
// rtl/shifter32.sv - fixed-latency multi-cycle 32-bit left shifter
// Purpose : shifts op1_i left by op2_i; result_o is valid while ready_o pulses,
//           LATENCY cycles after the start pulse.
// Ports   : clk, resetn (sync, active-low), start_i, op1_i, op2_i,
//           result_o, ready_o
module shifter32 #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [31:0] op1_i,
    input  logic [4:0]  op2_i,
    output logic [31:0] result_o,
    output logic        ready_o
);

    logic [3:0]  cnt_q;
    logic [31:0] val_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            val_q <= '0;
        end else if (start_i) begin
            cnt_q <= 4'(LATENCY);
            val_q <= op1_i << op2_i;
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign ready_o  = (cnt_q == 4'd1);
    assign result_o = ready_o ? val_q : '0;

endmodule

// File: rtl/shift_ctl.sv
// rtl/shift_ctl.sv - two-port front end sharing one left-only shifter
// Purpose : arbitrates port 0/1 requests, issues one start pulse to the shifter
//           with a pre-transformed operand, post-transforms the result and holds
//           it until the consumer accepts it.
// Ports   : i_clk, i_rst (async, active-high)
//           i_reqN_valid/op1/shamt/dir, o_reqN_ready - requester ports 0 and 1
//           o_sh_start/op1/op2, i_sh_result/ready    - shifter interface
//           o_rsp_valid/id/result, i_rsp_ready       - response interface
module shift_ctl
    import shift_ctl_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_op1,
    input  logic [4:0]  i_req0_shamt,
    input  logic [1:0]  i_req0_dir,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_op1,
    input  logic [4:0]  i_req1_shamt,
    input  logic [1:0]  i_req1_dir,
    output logic        o_req1_ready,
    output logic        o_sh_start,
    output logic [31:0] o_sh_op1,
    output logic [4:0]  o_sh_op2,
    input  logic [31:0] i_sh_result,
    input  logic        i_sh_ready,
    output logic        o_rsp_valid,
    output logic        o_rsp_id,
    output logic [31:0] o_rsp_result,
    input  logic        i_rsp_ready
);

    logic [3:0]  state_q, state_d;
    logic        rr_ptr_q;      // port preferred on the next contended grant
    logic [31:0] sh_op1_q;
    logic [4:0]  shamt_q;
    logic [1:0]  dir_q;
    logic        sign_q;
    logic        id_q;
    logic [31:0] rsp_result_q;

    logic        grant_valid;
    logic        grant_id;
    logic [31:0] sel_op1;
    logic [4:0]  sel_shamt;
    logic [1:0]  sel_dir;
    logic [31:0] pre_result;
    logic [31:0] post_result;

    // Arbitration (only meaningful in IDLE)
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == ST_IDLE && !i_rst) begin
            if (i_req0_valid && i_req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = (RR_EN != 1'b0) ? rr_ptr_q : 1'b0;
            end else if (i_req0_valid || i_req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = i_req1_valid;
            end
        end
    end

    assign sel_op1   = grant_id ? i_req1_op1   : i_req0_op1;
    assign sel_shamt = grant_id ? i_req1_shamt : i_req0_shamt;
    assign sel_dir   = grant_id ? i_req1_dir   : i_req0_dir;

    shift_ctl_xform u_pre (
        .operand_i (sel_op1),
        .dir_i     (sel_dir),
        .sign_i    (sel_op1[31]),
        .post_i    (1'b0),
        .result_o  (pre_result)
    );

    shift_ctl_xform u_post (
        .operand_i (i_sh_result),
        .dir_i     (dir_q),
        .sign_i    (sign_q),
        .post_i    (1'b1),
        .result_o  (post_result)
    );

    // FSM: state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant_valid) state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY:  if (i_sh_ready) state_d = ST_RESP;
            ST_RESP:  if (i_rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_req0_ready = grant_valid && !grant_id;
        o_req1_ready = grant_valid && grant_id;
        o_sh_start   = (state_q == ST_START);
        o_rsp_valid  = (state_q == ST_RESP);
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_q     <= 1'b0;
            sh_op1_q     <= '0;
            shamt_q      <= '0;
            dir_q        <= '0;
            sign_q       <= 1'b0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            if (grant_valid) begin
                rr_ptr_q <= ~grant_id;
                sh_op1_q <= pre_result;
                shamt_q  <= sel_shamt;
                dir_q    <= sel_dir;
                sign_q   <= sel_op1[31];
                id_q     <= grant_id;
            end
            if (state_q == ST_BUSY && i_sh_ready) begin
                rsp_result_q <= post_result;
            end
        end
    end

    assign o_sh_op1     = sh_op1_q;
    assign o_sh_op2     = shamt_q;
    assign o_rsp_id     = id_q;
    assign o_rsp_result = rsp_result_q;

endmodule
